// File: rtl/avalon_pio_pkg.sv
// rtl/avalon_pio_pkg.sv - register word addresses for the extended PIO port
package avalon_pio_pkg;

    localparam logic [2:0] PIO_ADDR_DATA     = 3'd0;
    localparam logic [2:0] PIO_ADDR_DIR      = 3'd1;
    localparam logic [2:0] PIO_ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] PIO_ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] PIO_ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] PIO_ADDR_OUTCLR   = 3'd5;
    localparam logic [2:0] PIO_ADDR_RISE_EN  = 3'd6;
    localparam logic [2:0] PIO_ADDR_FALL_EN  = 3'd7;

endpackage

// File: rtl/pio_input_sync.sv
// rtl/pio_input_sync.sv - input synchroniser chain with one-cycle history and raw edge detect
module pio_input_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] data_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            data_prev_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            data_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign data_in = sync_q[SYNC_STAGES-1];
    assign rise    = data_in & ~data_prev_q;
    assign fall    = ~data_in & data_prev_q;

endmodule

// File: rtl/avalon_pio_ext.sv
// rtl/avalon_pio_ext.sv - Avalon-MM PIO with direction, set/clear, edge capture and maskable irq
module avalon_pio_ext
    import avalon_pio_pkg::*;
#(
    parameter int          WIDTH       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] RESET_OUT   = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic [WIDTH-1:0] data_in, rise, fall;

    pio_input_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_input_sync (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .data_in (data_in),
        .rise    (rise),
        .fall    (fall)
    );

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] clr;

    assign wr_en = chipselect & ~write_n;
    assign wd    = writedata[WIDTH-1:0];
    assign clr   = (wr_en && address == PIO_ADDR_EDGE_CAP) ? wd : '0;

    always_comb begin
        data_out_d = data_out_q;
        oe_d       = oe_q;
        mask_d     = mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        if (wr_en) begin
            case (address)
                PIO_ADDR_DATA:     data_out_d = wd;
                PIO_ADDR_DIR:      oe_d       = wd;
                PIO_ADDR_IRQ_MASK: mask_d     = wd;
                PIO_ADDR_OUTSET:   data_out_d = data_out_q | wd;
                PIO_ADDR_OUTCLR:   data_out_d = data_out_q & ~wd;
                PIO_ADDR_RISE_EN:  rise_en_d  = wd;
                PIO_ADDR_FALL_EN:  fall_en_d  = wd;
                default: ;
            endcase
        end
        // Fresh edges are OR-ed after the clear so a coincident edge survives it
        edge_d = (edge_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
        irq_d  = |(mask_q & (edge_q | (data_in & ~rise_en_q & ~fall_en_q)));
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            PIO_ADDR_DATA:     readdata_d[WIDTH-1:0] = data_in;
            PIO_ADDR_DIR:      readdata_d[WIDTH-1:0] = oe_q;
            PIO_ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = mask_q;
            PIO_ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = edge_q;
            PIO_ADDR_RISE_EN:  readdata_d[WIDTH-1:0] = rise_en_q;
            PIO_ADDR_FALL_EN:  readdata_d[WIDTH-1:0] = fall_en_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= RESET_OUT[WIDTH-1:0];
            oe_q       <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            oe_q       <= oe_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = data_out_q;
    assign oe       = oe_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_avalon_pio_ext.sv
// tb/tb_avalon_pio_ext.sv - self-checking bench for avalon_pio_ext against a behavioural model
module tb_avalon_pio_ext;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] in_port;
    logic [31:0] out_port;
    logic [31:0] oe;
    logic        irq;

    logic [31:0] readdata8;
    logic [7:0]  out_port8;
    logic [7:0]  oe8;
    logic        irq8;

    always #5 clk = ~clk;

    avalon_pio_ext #(.WIDTH(32), .SYNC_STAGES(S), .RESET_OUT(32'h0000_00A5)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
    );

    avalon_pio_ext #(.WIDTH(8), .SYNC_STAGES(S), .RESET_OUT(32'h0000_00A5)) dut8 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata8),
        .in_port(in_port[7:0]), .out_port(out_port8), .oe(oe8), .irq(irq8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: the synchroniser is a plain delay line of input samples
    logic [31:0] m_sync [S];
    logic [31:0] m_prev, m_out, m_oe, m_mask, m_edge, m_rise, m_fall, m_rd;
    logic        m_irq;

    task automatic step();
        logic [31:0] din, clr, rd, edg;
        logic        wr, irqn;
        din = m_sync[S-1];
        wr  = chipselect && !write_n;
        if (reset) begin
            for (int i = 0; i < S; i++) m_sync[i] = '0;
            m_prev = '0; m_out = 32'hA5; m_oe = '0; m_mask = '0;
            m_edge = '0; m_rise = '0; m_fall = '0; m_rd = '0; m_irq = 1'b0;
        end else begin
            case (address)
                3'd0: rd = din;
                3'd1: rd = m_oe;
                3'd2: rd = m_mask;
                3'd3: rd = m_edge;
                3'd6: rd = m_rise;
                3'd7: rd = m_fall;
                default: rd = '0;
            endcase
            clr  = (wr && address == 3'd3) ? writedata : '0;
            edg  = (m_edge & ~clr) | (din & ~m_prev & m_rise) | (~din & m_prev & m_fall);
            irqn = (m_mask & (m_edge | (din & ~m_rise & ~m_fall))) != 0;
            if (wr) begin
                case (address)
                    3'd0: m_out = writedata;
                    3'd1: m_oe = writedata;
                    3'd2: m_mask = writedata;
                    3'd4: m_out = m_out | writedata;
                    3'd5: m_out = m_out & ~writedata;
                    3'd6: m_rise = writedata;
                    3'd7: m_fall = writedata;
                    default: ;
                endcase
            end
            for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = in_port;
            m_prev = din;
            m_edge = edg;
            m_rd   = rd;
            m_irq  = irqn;
        end
        @(posedge clk);
        #1;
        check("readdata", readdata, m_rd);
        check("out_port", out_port, m_out);
        check("oe", oe, m_oe);
        check("irq", {31'b0, irq}, {31'b0, m_irq});
        check("readdata8", readdata8, m_rd & 32'hFF);
        check("out_port8", {24'b0, out_port8}, m_out & 32'hFF);
        check("oe8", {24'b0, oe8}, m_oe & 32'hFF);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_expect(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        step();
        check(tag, readdata, exp);
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = 32'hFFFF_FFFF;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        check("rst_out_port", out_port, 32'h0000_00A5);
        check("rst_oe", oe, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        rd_expect("rst_edge_cap", 3'd3, 32'h0);
        step();
        rd_expect("rst_data_in", 3'd0, 32'hFFFF_FFFF);

        // Set/clear outputs
        wr(3'd0, 32'h0F0F_0000);
        wr(3'd4, 32'h0000_00FF);
        wr(3'd5, 32'h0F00_0000);
        check("setclr_out_port", out_port, 32'h000F_00FF);
        rd_expect("outset_reads0", 3'd4, 32'h0);
        rd_expect("outclr_reads0", 3'd5, 32'h0);

        // Width parameter on the narrow instance
        wr(3'd1, 32'hFFFF_FFFF);
        rd_expect("dir32_read", 3'd1, 32'hFFFF_FFFF);
        check("w8_dir_read", readdata8, 32'h0000_00FF);
        check("w8_oe", {24'b0, oe8}, 32'h0000_00FF);

        // Rising-edge interrupt
        in_port = 32'h0;
        repeat (4) step();
        wr(3'd6, 32'h1);
        wr(3'd2, 32'h1);
        address = 3'd3;
        in_port = 32'h1;
        repeat (S) step();
        step();
        check("rise_irq_early", {31'b0, irq}, 32'h0);
        check("rise_cap_early", readdata, 32'h0);
        step();
        check("rise_cap", readdata, 32'h1);
        check("rise_irq", {31'b0, irq}, 32'h1);
        wr(3'd3, 32'h1);
        check("irq_hold_on_clear", {31'b0, irq}, 32'h1);
        step();
        check("irq_cleared", {31'b0, irq}, 32'h0);
        check("cap_cleared", readdata, 32'h0);

        // Clear/edge collision on bit 1
        wr(3'd7, 32'h2);
        in_port = 32'h3;
        repeat (4) step();
        in_port = 32'h1;
        repeat (S) step();
        wr(3'd3, 32'h2);
        step();
        check("collision_keeps_bit", readdata, 32'h2);
        wr(3'd3, 32'hFFFF_FFFF);

        // Level interrupt on bit 3
        wr(3'd6, 32'h0);
        wr(3'd7, 32'h0);
        wr(3'd2, 32'h8);
        address = 3'd3;
        in_port = 32'h9;
        repeat (S) step();
        check("level_irq_early", {31'b0, irq}, 32'h0);
        step();
        check("level_irq", {31'b0, irq}, 32'h1);
        in_port = 32'h1;
        repeat (S) step();
        check("level_irq_hold", {31'b0, irq}, 32'h1);
        step();
        check("level_irq_drop", {31'b0, irq}, 32'h0);
        check("level_no_capture", readdata, 32'h0);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 60) == 0);
            address    = 3'($urandom_range(0, 7));
            chipselect = $urandom_range(0, 1) == 1;
            write_n    = $urandom_range(0, 2) != 0;
            writedata  = $urandom;
            if ($urandom_range(0, 3) == 0) in_port = in_port ^ ($urandom & $urandom & $urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
